neuron_frame_loader: RTL
========================

// Module: neuron_frame_loader
// PURPOSE
//  Host-side feeder for one 4-input neuron. Deserialises a byte stream into one operand frame:
//  X1..X4, W1..W4 and a 16-bit bias. Runs the neuron computation (weighted sum, >>>7, clamp).
//  Returns the 8-bit result on a valid/ready output channel.
//  Sits between the host byte link and the accelerator datapath; one frame in flight at a time.
// PARAMETERS
//  N_IN        4   inputs per neuron (frame = 2*N_IN + 2 bytes); only 4 is supported
//  EXEC_CYCLES 1   cycles spent in EXEC before the result is captured (>=1)
//  SHIFT       7   arithmetic right shift applied to the 19-bit sum before clamping
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous, active-low reset
//  s_data     in   8    input byte stream
//  s_valid    in   1    s_data valid
//  s_ready    out  1    loader accepts a byte (high only in LOAD)
//  cfg_xmin   in   12   signed clamp low bound; static while busy; must lie in [-128,127]
//  cfg_xmax   in   12   signed clamp high bound; static while busy; must be >= cfg_xmin
//  m_y        out  8    signed neuron output
//  m_valid    out  1    m_y valid
//  m_ready    in   1    consumer accepts m_y
//  busy       out  1    high in EXEC or OUT
//  byte_cnt   out  4    bytes accepted in the current frame (0..9)
// BEHAVIOUR
//  Reset: state=LOAD; byte_cnt=0; m_y=0; m_valid=0; busy=0; operand regs=0; s_ready=1 one
//   cycle after rst_n deasserts.
//  Byte order (index = byte_cnt): 0-3 = X1..X4; 4-7 = W1..W4; 8 = bias[7:0]; 9 = bias[15:8].
//   All operands are two's-complement.
//  Byte transfer = s_valid & s_ready on a rising edge. Each transfer writes operand reg[byte_cnt].
//   byte_cnt then increments.
//  LOAD: s_ready=1. The transfer at byte_cnt==9 sets byte_cnt to 0 and moves to EXEC.
//  EXEC: s_ready=0 and busy=1. An internal counter runs EXEC_CYCLES cycles.
//   On the last cycle the result is registered into m_y, m_valid is set to 1, and the state moves to OUT.
//  OUT: m_valid=1 and m_y is held stable until m_valid & m_ready.
//   On that cycle m_valid clears and the state returns to LOAD.
//   s_ready rises the following cycle (no same-cycle turnaround).
//  Arithmetic: sum[18:0] = X1*W1 + X2*W2 + X3*W3 + X4*W4 + sext(bias). Products are signed 16-bit.
//   Sign-extend each product and the bias to 19 bits before adding.
//   The 19-bit sum does not overflow for any 8-bit operands and 16-bit bias.
//  x[11:0] = sum[18:7]. Clamp: y12 = (x<xmin) ? xmin : (x>xmax) ? xmax : x. m_y = y12[7:0].
//  s_valid while s_ready=0 is ignored; no byte is consumed and byte_cnt holds.
//  m_ready while m_valid=0 has no effect.
//  Reset mid-frame or mid-OUT discards the partial frame or pending result; all regs return to reset values.
//  cfg_* are sampled combinationally in the EXEC capture cycle only.
//  FSM encoding: LOAD=2'd0, EXEC=2'd1, OUT=2'd2. Illegal state 2'd3 -> LOAD.
// STRUCTURE
//  Package neuron_pkg: state typedef (LOAD/EXEC/OUT), FRAME_BYTES=10, BIAS_LO_IDX=8,
//   BIAS_HI_IDX=9, SUM_W=19, ACT_W=12.
//  One sub-module: neuron_mac_clamp. Purely combinational: X1..X4, W1..W4, bias, xmin, xmax -> y[7:0].
//   It is instantiated once; its output is registered by this block.
//  This block holds only the FSM, counters, operand registers and handshake logic.
// TESTING
//  1 Frame X=1,2,3,4; W=1,1,1,1; bias=0x0100 (bytes 00,01); xmin=-100, xmax=100
//    -> sum=266, x=2, m_y=2. m_valid rises EXEC_CYCLES cycles after the 10th byte.
//  2 X=127 x4, W=127 x4, bias=0, xmax=100 -> sum=64516, x=504, m_y=100 (clamp high).
//  3 X=-128 x4, W=127 x4, bias=0, xmin=-100 -> sum=-65024, x=-508, m_y=-100 (0x9C, clamp low).
//  4 Backpressure: hold m_ready=0 for 20 cycles after m_valid.
//    -> m_y stable; s_ready=0 throughout; s_valid pulses are not consumed.
//    Release -> one handshake; s_ready=1 on the next cycle.
//  5 Gapped input: s_valid toggles randomly across two back-to-back frames
//    -> byte_cnt tracks accepted bytes only; two results match the reference model in order.
//  6 Assert rst_n=0 asynchronously after 5 bytes
//    -> m_valid=0 and byte_cnt=0 immediately.
//    Next full frame after release produces the correct result with no stale operands.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state type and frame/datapath sizes for the neuron frame loader
package neuron_pkg;
  typedef enum logic [1:0] {LOAD = 2'd0, EXEC = 2'd1, OUT = 2'd2} state_t;
  localparam int FRAME_BYTES = 10;
  localparam int BIAS_LO_IDX = 8;
  localparam int BIAS_HI_IDX = 9;
  localparam int SUM_W = 19;
  localparam int ACT_W = 12;
endpackage

// File: rtl/neuron_frame_loader_if.sv
// neuron_frame_loader_if: host byte stream in, neuron result out
interface neuron_frame_loader_if;
  logic [7:0] s_data;
  logic s_valid;
  logic s_ready;
  logic [7:0] m_y;
  logic m_valid;
  logic m_ready;
  modport master(output s_data, s_valid, m_ready, input s_ready, m_y, m_valid);
  modport slave(input s_data, s_valid, m_ready, output s_ready, m_y, m_valid);
endinterface

// File: rtl/neuron_mac_clamp.sv
// neuron_mac_clamp: combinational weighted sum + bias, arithmetic shift and clamp to 8 bits
module neuron_mac_clamp
  import neuron_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SHIFT = 7
) (
  input  logic [N_IN-1:0][7:0] x,
  input  logic [N_IN-1:0][7:0] w,
  input  logic signed [15:0] bias,
  input  logic signed [11:0] xmin,
  input  logic signed [11:0] xmax,
  output logic [7:0] y
);
  logic signed [SUM_W-1:0] sum;
  logic signed [15:0] p;
  logic signed [ACT_W-1:0] act;
  always_comb begin
    p = '0;
    sum = SUM_W'(bias);
    for (int i = 0; i < N_IN; i++) begin
      p = $signed(x[i]) * $signed(w[i]);
      sum = sum + SUM_W'(p);
    end
    act = ACT_W'(sum >>> SHIFT);
    y = 8'(act < xmin ? xmin : act > xmax ? xmax : act);
  end
endmodule

// File: rtl/neuron_frame_loader.sv
// neuron_frame_loader: deserialises one operand frame, runs the neuron, returns the result by valid/ready
module neuron_frame_loader
  import neuron_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int EXEC_CYCLES = 1,
  parameter int SHIFT = 7
) (
  input  logic clk,
  input  logic rst_n,
  neuron_frame_loader_if.slave bus,
  input  logic [11:0] cfg_xmin,
  input  logic [11:0] cfg_xmax,
  output logic busy,
  output logic [3:0] byte_cnt
);
  localparam int EW = EXEC_CYCLES > 1 ? $clog2(EXEC_CYCLES) : 1;
  state_t state, nxt;
  logic [FRAME_BYTES-1:0][7:0] ops;
  logic [EW-1:0] ecnt;
  logic ready_q, xfer, last_byte, exec_done;
  logic [7:0] y;
  assign xfer = bus.s_valid & ready_q;
  assign last_byte = byte_cnt == 4'(FRAME_BYTES - 1);
  assign exec_done = state == EXEC && ecnt == EW'(EXEC_CYCLES - 1);
  // s_ready is registered so it only rises the cycle after reset release or a result handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LOAD;
      ready_q <= 1'b0;
    end else begin
      state <= nxt;
      ready_q <= nxt == LOAD;
    end
  always_comb
    nxt = state == LOAD ? (xfer && last_byte ? EXEC : LOAD) :
          state == EXEC ? (exec_done ? OUT : EXEC) :
          state == OUT  ? (bus.m_ready ? LOAD : OUT) : LOAD;
  always_comb begin
    bus.s_ready = ready_q;
    bus.m_valid = state == OUT;
    busy = state == EXEC || state == OUT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      byte_cnt <= '0;
      ops <= '0;
      ecnt <= '0;
      bus.m_y <= '0;
    end else begin
      if (xfer) begin
        ops[byte_cnt] <= bus.s_data;
        byte_cnt <= last_byte ? 4'd0 : byte_cnt + 4'd1;
      end
      ecnt <= state == EXEC && !exec_done ? ecnt + 1'b1 : '0;
      if (exec_done) bus.m_y <= y;
    end
  neuron_mac_clamp #(.N_IN(N_IN), .SHIFT(SHIFT)) u_mac (
    .x(ops[N_IN-1:0]),
    .w(ops[2*N_IN-1:N_IN]),
    .bias({ops[BIAS_HI_IDX], ops[BIAS_LO_IDX]}),
    .xmin(cfg_xmin),
    .xmax(cfg_xmax),
    .y(y)
  );
endmodule
